// File: rtl/scurve_sweep_scheduler_if.sv
// S-curve sweep scheduler bundle: command, parameters,
// SC-load / acquisition handshakes and status.
interface scurve_sweep_scheduler_if #(
  parameter int DAC_W = 10,
  parameter int CH_W  = 6
);
  logic             SweepStart;
  logic             SweepStop;
  logic [DAC_W-1:0] StartDAC;
  logic [DAC_W-1:0] EndDAC;
  logic [DAC_W-1:0] DACStep;
  logic [CH_W-1:0]  ChannelStart;
  logic [CH_W-1:0]  ChannelEnd;
  logic [DAC_W-1:0] OutDAC;
  logic [CH_W-1:0]  OutChannel;
  logic             LoadSCParameter;
  logic             MicrorocConfigDone;
  logic             SingleACQStart;
  logic             ACQDone;
  logic             DataTransmitDone;
  logic             ForceMicrorocAcqReset;
  logic             SweepBusy;
  logic             SweepDone;
  logic             ParamError;
  logic             TimeoutError;

  modport master (
    output SweepStart, SweepStop,
    output StartDAC, EndDAC, DACStep,
    output ChannelStart, ChannelEnd,
    output MicrorocConfigDone, ACQDone,
    output DataTransmitDone,
    input  OutDAC, OutChannel,
    input  LoadSCParameter, SingleACQStart,
    input  ForceMicrorocAcqReset,
    input  SweepBusy, SweepDone,
    input  ParamError, TimeoutError
  );

  modport slave (
    input  SweepStart, SweepStop,
    input  StartDAC, EndDAC, DACStep,
    input  ChannelStart, ChannelEnd,
    input  MicrorocConfigDone, ACQDone,
    input  DataTransmitDone,
    output OutDAC, OutChannel,
    output LoadSCParameter, SingleACQStart,
    output ForceMicrorocAcqReset,
    output SweepBusy, SweepDone,
    output ParamError, TimeoutError
  );
endinterface

// File: rtl/scurve_sweep_scheduler.sv
// Channel x DAC0 S-curve sweep sequencer: per point
// reload SC, wait config, fire one ACQ, wait ACQ + USB.
module scurve_sweep_scheduler #(
  parameter int DAC_W   = 10,
  parameter int CH_W    = 6,
  parameter int CFG_TMO = 4096,
  parameter int ACQ_TMO = 2**20
) (
  input logic Clk,
  input logic reset,
  scurve_sweep_scheduler_if.slave bus
);

  localparam int TMO_MAX = (ACQ_TMO > CFG_TMO) ?
                           ACQ_TMO : CFG_TMO;
  localparam int TMR_W = $clog2(TMO_MAX) + 1;
  localparam logic [TMR_W-1:0] CFG_LAST =
    TMR_W'(CFG_TMO - 1);
  localparam logic [TMR_W-1:0] ACQ_LAST =
    TMR_W'(ACQ_TMO - 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LOAD     = 4'd1;
  localparam logic [3:0] WAIT_CFG = 4'd2;
  localparam logic [3:0] START    = 4'd3;
  localparam logic [3:0] WAIT_ACQ = 4'd4;
  localparam logic [3:0] WAIT_TX  = 4'd5;
  localparam logic [3:0] NEXT     = 4'd6;
  localparam logic [3:0] ABORT    = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  logic [3:0]       state;
  logic [TMR_W-1:0] timer;
  logic [DAC_W-1:0] start_dac;
  logic [DAC_W-1:0] end_dac;
  logic [DAC_W-1:0] dac_step;
  logic [CH_W-1:0]  ch_end;
  logic [DAC_W-1:0] out_dac;
  logic [CH_W-1:0]  out_ch;
  logic             load_sc;
  logic             acq_start;
  logic             force_rst;
  logic             busy;
  logic             sweep_done;
  logic             param_err;
  logic             tmo_err;
  logic             stop_hit;
  logic             param_bad;
  logic [DAC_W:0]   nxt_dac;

  assign stop_hit = bus.SweepStop &&
    !(state inside {IDLE, DONE, ABORT});
  assign param_bad = (bus.StartDAC > bus.EndDAC) ||
                     (bus.DACStep == '0) ||
                     (bus.ChannelStart > bus.ChannelEnd);
  // One extra bit catches the carry past full scale.
  assign nxt_dac = {1'b0, out_dac} + {1'b0, dac_step};

  // Sweep FSM; request pulses lag their state by a cycle.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      start_dac  <= '0;
      end_dac    <= '0;
      dac_step   <= '0;
      ch_end     <= '0;
      out_dac    <= '0;
      out_ch     <= '0;
      load_sc    <= 1'b0;
      acq_start  <= 1'b0;
      force_rst  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      param_err  <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      load_sc    <= 1'b0;
      acq_start  <= 1'b0;
      force_rst  <= 1'b0;
      sweep_done <= 1'b0;
      if (stop_hit) begin
        force_rst <= 1'b1;
        state     <= ABORT;
      end else begin
        case (state)
          IDLE: if (bus.SweepStart) begin
            start_dac <= bus.StartDAC;
            end_dac   <= bus.EndDAC;
            dac_step  <= bus.DACStep;
            ch_end    <= bus.ChannelEnd;
            if (param_bad) begin
              param_err <= 1'b1;
            end else begin
              param_err <= 1'b0;
              tmo_err   <= 1'b0;
              out_dac   <= bus.StartDAC;
              out_ch    <= bus.ChannelStart;
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            load_sc <= 1'b1;
            timer   <= '0;
            state   <= WAIT_CFG;
          end
          WAIT_CFG: begin
            if (bus.MicrorocConfigDone) begin
              state <= START;
            end else if (timer == CFG_LAST) begin
              tmo_err   <= 1'b1;
              force_rst <= 1'b1;
              state     <= ABORT;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          START: begin
            acq_start <= 1'b1;
            timer     <= '0;
            state     <= WAIT_ACQ;
          end
          WAIT_ACQ: begin
            if (bus.ACQDone && bus.DataTransmitDone) begin
              state <= NEXT;
            end else if (timer == ACQ_LAST) begin
              tmo_err   <= 1'b1;
              force_rst <= 1'b1;
              state     <= ABORT;
            end else begin
              timer <= timer + 1'b1;
              if (bus.ACQDone) state <= WAIT_TX;
            end
          end
          WAIT_TX: begin
            if (bus.DataTransmitDone) begin
              state <= NEXT;
            end else if (timer == ACQ_LAST) begin
              tmo_err   <= 1'b1;
              force_rst <= 1'b1;
              state     <= ABORT;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          NEXT: begin
            if (nxt_dac <= {1'b0, end_dac}) begin
              out_dac <= nxt_dac[DAC_W-1:0];
              state   <= LOAD;
            end else if (out_ch < ch_end) begin
              out_ch  <= out_ch + 1'b1;
              out_dac <= start_dac;
              state   <= LOAD;
            end else begin
              sweep_done <= 1'b1;
              state      <= DONE;
            end
          end
          ABORT: begin
            sweep_done <= 1'b1;
            state      <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.OutDAC                = out_dac;
  assign bus.OutChannel            = out_ch;
  assign bus.LoadSCParameter       = load_sc;
  assign bus.SingleACQStart        = acq_start;
  assign bus.ForceMicrorocAcqReset = force_rst;
  assign bus.SweepBusy             = busy;
  assign bus.SweepDone             = sweep_done;
  assign bus.ParamError            = param_err;
  assign bus.TimeoutError          = tmo_err;

endmodule

// File: tb/tb_scurve_sweep_scheduler.sv
// Directed bench for scurve_sweep_scheduler: table of
// sweeps plus latency, timeout, stop and reset sequences.
module tb_scurve_sweep_scheduler;

  localparam int DAC_W   = 10;
  localparam int CH_W    = 6;
  localparam int CFG_TMO = 16;
  localparam int ACQ_TMO = 64;

  typedef struct {
    int s;
    int e;
    int st;
    int cs;
    int ce;
    int pts;
    int perr;
  } vec_t;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  always #5 Clk = ~Clk;

  scurve_sweep_scheduler_if #(
    .DAC_W(DAC_W), .CH_W(CH_W)
  ) bus ();

  scurve_sweep_scheduler #(
    .DAC_W(DAC_W), .CH_W(CH_W),
    .CFG_TMO(CFG_TMO), .ACQ_TMO(ACQ_TMO)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .bus(bus.slave)
  );

  logic auto_cfg = 1'b1;
  logic auto_acq = 1'b1;
  logic man_cfg  = 1'b0;
  logic man_acq  = 1'b0;
  logic man_tx   = 1'b0;

  assign bus.MicrorocConfigDone =
    man_cfg | (auto_cfg & bus.LoadSCParameter);
  assign bus.ACQDone =
    man_acq | (auto_acq & bus.SingleACQStart);
  assign bus.DataTransmitDone =
    man_tx | (auto_acq & bus.SingleACQStart);

  int n_load  = 0;
  int n_acq   = 0;
  int n_done  = 0;
  int n_force = 0;
  int n_busy  = 0;
  int q_dac[$];
  int q_ch[$];

  always @(posedge Clk) begin
    #1;
    if (bus.LoadSCParameter) n_load++;
    if (bus.SweepDone) n_done++;
    if (bus.ForceMicrorocAcqReset) n_force++;
    if (bus.SweepBusy) n_busy++;
    if (bus.SingleACQStart) begin
      n_acq++;
      q_dac.push_back(int'(bus.OutDAC));
      q_ch.push_back(int'(bus.OutChannel));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.OutDAC, bus.OutChannel,
                 bus.LoadSCParameter, bus.SingleACQStart,
                 bus.ForceMicrorocAcqReset, bus.SweepBusy,
                 bus.SweepDone, bus.ParamError,
                 bus.TimeoutError});
  endfunction

  task automatic set_params(input vec_t v);
    bus.StartDAC     = DAC_W'(v.s);
    bus.EndDAC       = DAC_W'(v.e);
    bus.DACStep      = DAC_W'(v.st);
    bus.ChannelStart = CH_W'(v.cs);
    bus.ChannelEnd   = CH_W'(v.ce);
  endtask

  task automatic pulse_start();
    bus.SweepStart = 1'b1;
    @(negedge Clk);
    bus.SweepStart = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k;
    k = 0;
    while (n_done == d0 && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    check(nm, int'(k < 3000), 1);
  endtask

  task automatic wait_acq_start(input string nm);
    int k;
    k = 0;
    while (!bus.SingleACQStart && k < 40) begin
      @(negedge Clk);
      k++;
    end
    check(nm, int'(bus.SingleACQStart), 1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int l0, a0, d0, b0, base, idx, bad_pts;
    int last_d, last_c;
    l0 = n_load; a0 = n_acq; d0 = n_done; b0 = n_busy;
    base = q_dac.size();
    auto_cfg = 1'b1;
    auto_acq = 1'b1;
    set_params(v);
    pulse_start();
    if (v.perr != 0) begin
      repeat (6) @(negedge Clk);
      check($sformatf("v%0d_busy", id), n_busy - b0, 0);
    end else begin
      wait_done(d0, $sformatf("v%0d_finish", id));
      repeat (2) @(negedge Clk);
      bad_pts = 0; idx = base; last_d = 0; last_c = 0;
      for (int c = v.cs; c <= v.ce; c++) begin
        for (int d = v.s; d <= v.e; d += v.st) begin
          if (idx >= q_dac.size()) bad_pts++;
          else if (q_dac[idx] != d || q_ch[idx] != c)
            bad_pts++;
          idx++;
          last_d = d;
          last_c = c;
        end
      end
      check($sformatf("v%0d_seq", id), bad_pts, 0);
      check($sformatf("v%0d_lastdac", id),
            int'(bus.OutDAC), last_d);
      check($sformatf("v%0d_lastch", id),
            int'(bus.OutChannel), last_c);
      check($sformatf("v%0d_busy_end", id),
            int'(bus.SweepBusy), 0);
    end
    check($sformatf("v%0d_points", id), n_acq - a0, v.pts);
    check($sformatf("v%0d_loads", id), n_load - l0, v.pts);
    check($sformatf("v%0d_done", id), n_done - d0,
          (v.perr != 0) ? 0 : 1);
    check($sformatf("v%0d_perr", id),
          int'(bus.ParamError), v.perr);
    check($sformatf("v%0d_terr", id),
          int'(bus.TimeoutError), 0);
  endtask

  vec_t vecs[8];

  initial begin
    int a0, d0, f0;
    vec_t v;
    vecs[0] = '{475, 525, 1, 0, 0, 51, 0};
    vecs[1] = '{1020, 1023, 2, 3, 4, 4, 0};
    vecs[2] = '{0, 9, 3, 62, 63, 8, 0};
    vecs[3] = '{1023, 1023, 5, 63, 63, 1, 0};
    vecs[4] = '{600, 500, 1, 0, 0, 0, 1};
    vecs[5] = '{5, 5, 0, 0, 0, 0, 1};
    vecs[6] = '{1, 2, 1, 5, 4, 0, 1};
    vecs[7] = '{10, 20, 7, 1, 1, 2, 0};

    bus.SweepStart = 1'b0;
    bus.SweepStop  = 1'b0;
    v = '{0, 0, 1, 0, 0, 0, 0};
    set_params(v);
    repeat (3) @(negedge Clk);
    check("reset_outs", outs(), 0);
    reset = 1'b0;
    @(negedge Clk);
    check("idle_outs", outs(), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // start/config latency
    v = '{100, 101, 1, 2, 2, 2, 0};
    set_params(v);
    auto_cfg = 1'b0;
    d0 = n_done;
    pulse_start();
    check("busy_1cyc", int'(bus.SweepBusy), 1);
    check("load_not_1cyc", int'(bus.LoadSCParameter), 0);
    @(negedge Clk);
    check("load_2cyc", int'(bus.LoadSCParameter), 1);
    repeat (3) @(negedge Clk);
    man_cfg = 1'b1;
    @(negedge Clk);
    man_cfg = 1'b0;
    check("acq_not_1cyc", int'(bus.SingleACQStart), 0);
    @(negedge Clk);
    check("acq_2cyc", int'(bus.SingleACQStart), 1);
    auto_cfg = 1'b1;
    wait_done(d0, "lat_finish");
    repeat (2) @(negedge Clk);

    // config timeout
    v = '{0, 3, 1, 0, 0, 0, 0};
    set_params(v);
    auto_cfg = 1'b0;
    a0 = n_acq;
    pulse_start();
    @(negedge Clk);
    check("tmo_load", int'(bus.LoadSCParameter), 1);
    repeat (CFG_TMO - 1) @(negedge Clk);
    check("tmo_early", int'(bus.TimeoutError), 0);
    @(negedge Clk);
    check("tmo_set", int'(bus.TimeoutError), 1);
    check("tmo_force", int'(bus.ForceMicrorocAcqReset), 1);
    @(negedge Clk);
    check("tmo_done", int'(bus.SweepDone), 1);
    check("tmo_force_1cyc",
          int'(bus.ForceMicrorocAcqReset), 0);
    @(negedge Clk);
    check("tmo_busy_off", int'(bus.SweepBusy), 0);
    check("tmo_no_acq", n_acq - a0, 0);
    auto_cfg = 1'b1;

    // stop during WAIT_ACQ of the third point
    v = '{0, 9, 1, 0, 0, 0, 0};
    set_params(v);
    auto_acq = 1'b0;
    a0 = n_acq;
    pulse_start();
    check("stop_clears_terr", int'(bus.TimeoutError), 0);
    for (int p = 1; p <= 3; p++) begin
      wait_acq_start($sformatf("stop_pt%0d", p));
      if (p < 3) begin
        man_acq = 1'b1;
        man_tx  = 1'b1;
        @(negedge Clk);
        man_acq = 1'b0;
        man_tx  = 1'b0;
      end
    end
    @(negedge Clk);
    bus.SweepStop = 1'b1;
    @(negedge Clk);
    bus.SweepStop = 1'b0;
    check("stop_force", int'(bus.ForceMicrorocAcqReset), 1);
    check("stop_done_early", int'(bus.SweepDone), 0);
    @(negedge Clk);
    check("stop_done", int'(bus.SweepDone), 1);
    repeat (10) @(negedge Clk);
    check("stop_acq_count", n_acq - a0, 3);

    // synchronous reset inside WAIT_TX
    v = '{300, 302, 1, 7, 7, 3, 0};
    set_params(v);
    pulse_start();
    wait_acq_start("rst_pt");
    man_acq = 1'b1;
    @(negedge Clk);
    man_acq = 1'b0;
    d0 = n_done;
    f0 = n_force;
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check("rst_outs", outs(), 0);
    repeat (5) @(negedge Clk);
    check("rst_silent",
          (n_done - d0) + (n_force - f0), 0);
    auto_acq = 1'b1;
    run_vec(v, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
